// File: rtl/neutron_pkg.sv
// Shared types and helpers for the neutron pulse analyzer: FSM states,
// event record layout and saturating counters.
package neutron_pkg;

  localparam int TIME_W   = 16;
  localparam int WIDTH_W  = 16;
  localparam int NAFTER_W = 8;
  localparam int AFTER_W  = 16;
  localparam int REC_W    = TIME_W + WIDTH_W + NAFTER_W + AFTER_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAIN_HIGH,
    S_GAP,
    S_AFTER_HIGH
  } state_t;

  typedef struct packed {
    logic [TIME_W-1:0]   evtTime;
    logic [WIDTH_W-1:0]  width;
    logic [NAFTER_W-1:0] nafter;
    logic [AFTER_W-1:0]  afterTime;
  } evt_rec_t;

  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? 16'hFFFF : value + 16'd1;
  endfunction

  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? 8'hFF : value + 8'd1;
  endfunction

endpackage

// File: rtl/neutron_evt_outreg.sv
// One-deep event record holding register with valid/ready handshake.
// A close that finds the register occupied and not draining is dropped and counted.
module neutron_evt_outreg
  import neutron_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_close,
  input  logic [REC_W-1:0] i_rec,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [REC_W-1:0] o_rec,
  output logic [15:0]      o_dropCount
);

  logic             r_valid;
  logic [REC_W-1:0] r_rec;
  logic [15:0]      r_dropCount;
  logic             w_canLoad;

  assign w_canLoad = !r_valid || i_ready;

  // A load on the same edge as a transfer keeps valid high with the new record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_rec       <= '0;
      r_dropCount <= '0;
    end else begin
      if (i_close && w_canLoad) begin
        r_rec   <= i_rec;
        r_valid <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
      if (i_close && !w_canLoad) begin
        r_dropCount <= satInc16(r_dropCount);
      end
    end
  end

  assign o_valid     = r_valid;
  assign o_rec       = r_rec;
  assign o_dropCount = r_dropCount;

endmodule

// File: rtl/neutron_pulse_analyzer.sv
// Splits the pulse stream into main pulse plus afterpulse train, measures each
// group and hands one record per group to the output register.
module neutron_pulse_analyzer
  import neutron_pkg::*;
#(
  parameter int MAIN_MIN_WIDTH = 16,
  parameter int GROUP_GAP      = 64
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        PULSE_IN,
  input  logic        EVT_READY,
  output logic        EVT_VALID,
  output logic [15:0] EVT_TIME,
  output logic [15:0] EVT_WIDTH,
  output logic [7:0]  EVT_NAFTER,
  output logic [15:0] EVT_AFTERTIME,
  output logic [15:0] DROP_COUNT,
  output logic [15:0] NOISE_COUNT,
  output logic        BUSY
);

  state_t      r_state, w_stateNxt;
  logic        r_pq;
  logic [15:0] r_timebase;
  logic [15:0] r_tCap, w_tCapNxt;
  logic [15:0] r_width, w_widthNxt;
  logic [7:0]  r_nafter, w_nafterNxt;
  logic [15:0] r_afterTime, w_afterTimeNxt;
  logic [15:0] r_gapCnt, w_gapCntNxt;
  logic [15:0] r_noiseCount, w_noiseCountNxt;
  logic        w_rise, w_fall, w_close;
  evt_rec_t    w_rec, w_outRec;

  assign w_rise = PULSE_IN && !r_pq;
  assign w_fall = !PULSE_IN && r_pq;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_pq         <= 1'b0;
      r_timebase   <= '0;
      r_tCap       <= '0;
      r_width      <= '0;
      r_nafter     <= '0;
      r_afterTime  <= '0;
      r_gapCnt     <= '0;
      r_noiseCount <= '0;
    end else begin
      r_state      <= w_stateNxt;
      r_pq         <= PULSE_IN;
      r_timebase   <= r_timebase + 16'd1;
      r_tCap       <= w_tCapNxt;
      r_width      <= w_widthNxt;
      r_nafter     <= w_nafterNxt;
      r_afterTime  <= w_afterTimeNxt;
      r_gapCnt     <= w_gapCntNxt;
      r_noiseCount <= w_noiseCountNxt;
    end
  end

  // A rise in GAP wins over the gap timeout, so a late afterpulse keeps the group open.
  always_comb begin
    w_stateNxt      = r_state;
    w_tCapNxt       = r_tCap;
    w_widthNxt      = r_width;
    w_nafterNxt     = r_nafter;
    w_afterTimeNxt  = r_afterTime;
    w_gapCntNxt     = r_gapCnt;
    w_noiseCountNxt = r_noiseCount;
    w_close         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_tCapNxt  = r_timebase;
          w_widthNxt = 16'd1;
          w_stateNxt = S_MAIN_HIGH;
        end
      end
      S_MAIN_HIGH: begin
        if (w_fall) begin
          if (r_width >= 16'(MAIN_MIN_WIDTH)) begin
            w_nafterNxt    = '0;
            w_afterTimeNxt = '0;
            w_gapCntNxt    = '0;
            w_stateNxt     = S_GAP;
          end else begin
            w_noiseCountNxt = satInc16(r_noiseCount);
            w_stateNxt      = S_IDLE;
          end
        end else if (PULSE_IN) begin
          w_widthNxt = satInc16(r_width);
        end
      end
      S_GAP: begin
        if (w_rise) begin
          w_nafterNxt    = satInc8(r_nafter);
          w_afterTimeNxt = satInc16(r_afterTime);
          w_gapCntNxt    = '0;
          w_stateNxt     = S_AFTER_HIGH;
        end else if (r_gapCnt == 16'(GROUP_GAP - 1)) begin
          w_close    = 1'b1;
          w_stateNxt = S_IDLE;
        end else begin
          w_gapCntNxt = r_gapCnt + 16'd1;
        end
      end
      S_AFTER_HIGH: begin
        if (w_fall) begin
          w_gapCntNxt = '0;
          w_stateNxt  = S_GAP;
        end else begin
          w_afterTimeNxt = satInc16(r_afterTime);
        end
      end
      default: w_stateNxt = S_IDLE;
    endcase
  end

  assign w_rec = '{evtTime: r_tCap, width: r_width, nafter: r_nafter, afterTime: r_afterTime};

  neutron_evt_outreg u_outreg (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .i_close     (w_close),
    .i_rec       (w_rec),
    .i_ready     (EVT_READY),
    .o_valid     (EVT_VALID),
    .o_rec       (w_outRec),
    .o_dropCount (DROP_COUNT)
  );

  assign EVT_TIME      = w_outRec.evtTime;
  assign EVT_WIDTH     = w_outRec.width;
  assign EVT_NAFTER    = w_outRec.nafter;
  assign EVT_AFTERTIME = w_outRec.afterTime;
  assign NOISE_COUNT   = r_noiseCount;
  assign BUSY          = (r_state != S_IDLE);

endmodule

// File: tb/tb_neutron_pulse_analyzer.sv
// Directed scoreboard bench for neutron_pulse_analyzer: expected records are
// queued as each group is driven and checked when EVT_VALID presents them.
module tb_neutron_pulse_analyzer;

  logic        clk;
  logic        resetN;
  logic        pulseIn;
  logic        evtReady;
  logic        evtValid;
  logic [15:0] evtTime;
  logic [15:0] evtWidth;
  logic [7:0]  evtNafter;
  logic [15:0] evtAfterTime;
  logic [15:0] dropCount;
  logic [15:0] noiseCount;
  logic        busy;

  int          testsRun;
  int          failCount;
  logic [15:0] tbCount;
  logic [55:0] expQ[$];

  neutron_pulse_analyzer #(.MAIN_MIN_WIDTH(16), .GROUP_GAP(64)) dut (
    .CLK           (clk),
    .RESET_N       (resetN),
    .PULSE_IN      (pulseIn),
    .EVT_READY     (evtReady),
    .EVT_VALID     (evtValid),
    .EVT_TIME      (evtTime),
    .EVT_WIDTH     (evtWidth),
    .EVT_NAFTER    (evtNafter),
    .EVT_AFTERTIME (evtAfterTime),
    .DROP_COUNT    (dropCount),
    .NOISE_COUNT   (noiseCount),
    .BUSY          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timebase: free-running from reset release, wraps at 16 bits.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) tbCount <= 16'd0;
    else         tbCount <= tbCount + 16'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives highCycles sampled-high cycles then lowCycles low; starts and ends on a negedge.
  task automatic applyStimulus(input int highCycles, input int lowCycles);
    pulseIn = 1'b1;
    repeat (highCycles) @(negedge clk);
    pulseIn = 1'b0;
    repeat (lowCycles) @(negedge clk);
  endtask

  task automatic waitValid(input string tag, input int maxCycles);
    logic found;
    found = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      if (evtValid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_arrived"}, 32'(found), 32'd1);
  endtask

  task automatic watchNoValid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen = seen | evtValid;
    end
    checkOutput({tag, "_noValid"}, 32'(seen), 32'd0);
  endtask

  task automatic compareRecord(input string tag);
    logic [55:0] exp;
    checkOutput({tag, "_pending"}, 32'(expQ.size() != 0), 32'd1);
    if (expQ.size() == 0) return;
    exp = expQ.pop_front();
    checkOutput({tag, "_time"},      32'(evtTime),      32'(exp[55:40]));
    checkOutput({tag, "_width"},     32'(evtWidth),     32'(exp[39:24]));
    checkOutput({tag, "_nafter"},    32'(evtNafter),    32'(exp[23:16]));
    checkOutput({tag, "_aftertime"}, 32'(evtAfterTime), 32'(exp[15:0]));
  endtask

  initial begin
    logic [15:0] t;
    testsRun  = 0;
    failCount = 0;
    resetN    = 1'b0;
    pulseIn   = 1'b0;
    evtReady  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(evtValid), 32'd0);
    checkOutput("rst_fields", 32'({evtTime, evtWidth} | {16'd0, evtNafter, evtAfterTime[7:0]}), 32'd0);
    checkOutput("rst_drop", 32'(dropCount), 32'd0);
    checkOutput("rst_noise", 32'(noiseCount), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    resetN = 1'b1;

    // Main pulse at timebase 32 with eight 2-high/3-low afterpulses.
    while (tbCount != 16'd32) @(negedge clk);
    expQ.push_back({16'd32, 16'd86, 8'd8, 16'd16});
    applyStimulus(86, 3);
    repeat (7) applyStimulus(2, 3);
    applyStimulus(2, 0);
    repeat (64) @(negedge clk);
    checkOutput("A_closeEarly", 32'(evtValid), 32'd0);
    @(negedge clk);
    checkOutput("A_closeLatency", 32'(evtValid), 32'd1);
    compareRecord("A");
    @(negedge clk);
    checkOutput("A_transferred", 32'(evtValid), 32'd0);
    checkOutput("A_busyIdle", 32'(busy), 32'd0);

    // Short isolated pulses are noise; exactly MAIN_MIN_WIDTH is a main pulse.
    applyStimulus(10, 1);
    checkOutput("N10_noise", 32'(noiseCount), 32'd1);
    checkOutput("N10_busy", 32'(busy), 32'd0);
    watchNoValid("N10", 70);
    applyStimulus(15, 1);
    checkOutput("N15_noise", 32'(noiseCount), 32'd2);
    watchNoValid("N15", 70);
    t = tbCount;
    expQ.push_back({t, 16'd16, 8'd0, 16'd0});
    applyStimulus(16, 0);
    waitValid("W16", 80);
    compareRecord("W16");
    checkOutput("W16_noise", 32'(noiseCount), 32'd2);
    @(negedge clk);

    // Second group closes while the first is held; ready rises for exactly that edge.
    evtReady = 1'b0;
    t = tbCount;
    expQ.push_back({t, 16'd20, 8'd0, 16'd0});
    applyStimulus(20, 0);
    waitValid("SA", 80);
    t = tbCount;
    applyStimulus(25, 0);
    repeat (64) @(negedge clk);
    checkOutput("SA_heldValid", 32'(evtValid), 32'd1);
    compareRecord("SA");
    expQ.push_back({t, 16'd25, 8'd0, 16'd0});
    evtReady = 1'b1;
    @(negedge clk);
    checkOutput("SB_stillValid", 32'(evtValid), 32'd1);
    compareRecord("SB");
    checkOutput("SB_drop", 32'(dropCount), 32'd0);
    @(negedge clk);
    checkOutput("SB_transferred", 32'(evtValid), 32'd0);

    // Backpressure: second record is dropped, first held stable.
    evtReady = 1'b0;
    t = tbCount;
    expQ.push_back({t, 16'd20, 8'd1, 16'd3});
    applyStimulus(20, 2);
    applyStimulus(3, 0);
    waitValid("D1", 80);
    applyStimulus(30, 0);
    repeat (64) @(negedge clk);
    checkOutput("D_dropBefore", 32'(dropCount), 32'd0);
    @(negedge clk);
    checkOutput("D_drop", 32'(dropCount), 32'd1);
    checkOutput("D_heldValid", 32'(evtValid), 32'd1);
    compareRecord("D1");
    evtReady = 1'b1;
    @(negedge clk);
    checkOutput("D_transferred", 32'(evtValid), 32'd0);
    watchNoValid("D2", 10);

    // Reset mid-afterpulse train discards the group; next group is clean.
    applyStimulus(20, 3);
    applyStimulus(2, 3);
    pulseIn = 1'b1;
    @(negedge clk);
    checkOutput("R_busyBefore", 32'(busy), 32'd1);
    resetN = 1'b0;
    #1;
    checkOutput("R_valid", 32'(evtValid), 32'd0);
    checkOutput("R_fields", 32'({evtTime, evtWidth} | {16'd0, evtNafter, evtAfterTime[7:0]}), 32'd0);
    checkOutput("R_drop", 32'(dropCount), 32'd0);
    checkOutput("R_noise", 32'(noiseCount), 32'd0);
    checkOutput("R_busy", 32'(busy), 32'd0);
    pulseIn = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    watchNoValid("R", 80);
    t = tbCount;
    expQ.push_back({t, 16'd40, 8'd2, 16'd2});
    applyStimulus(40, 2);
    applyStimulus(1, 2);
    applyStimulus(1, 0);
    waitValid("RC", 80);
    compareRecord("RC");
    @(negedge clk);

    // Width saturation on a pulse that spans the timebase wrap, then a post-wrap group.
    t = tbCount;
    expQ.push_back({t, 16'hFFFF, 8'd0, 16'd0});
    applyStimulus(70000, 0);
    waitValid("L", 80);
    compareRecord("L");
    @(negedge clk);
    t = tbCount;
    expQ.push_back({t, 16'd17, 8'd0, 16'd0});
    applyStimulus(17, 0);
    waitValid("WR", 80);
    compareRecord("WR");
    checkOutput("final_drop", 32'(dropCount), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
